// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the operand-forwarding / load-use stall unit.
//   fwd_src_e  : where an operand was taken from (registered per source)
//   hz_state_e : observational hazard FSM state
package hazard_pkg;

  typedef enum logic [2:0] {
    FWD_RF       = 3'd0,
    FWD_EX       = 3'd1,
    FWD_MEM_ALU  = 3'd2,
    FWD_MEM_LOAD = 3'd3,
    FWD_WB       = 3'd4
  } fwd_src_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_fwd_mux.sv
// hazard_fwd_mux: combinational priority select for one ID source operand.
// Priority EX > MEM > WB > RF; index 0 is the hard-wired zero register.
// Ports:
//   rs_index_i / rs_value_i     : source index and register-file value
//   ex_*, mem_*, wb_*           : producer stage state
//   value_o / src_o             : selected operand and its origin
//   ex_load_hz_o                : operand is produced by a load still in EX
//   mem_wait_hz_o               : operand is produced by a load in MEM, data not ready
module hazard_fwd_mux
  import hazard_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs_index_i,
  input  logic [XLEN-1:0]  rs_value_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_load_i,
  input  logic [REG_W-1:0] ex_rd_index_i,
  input  logic [XLEN-1:0]  ex_result_i,
  input  logic             mem_valid_i,
  input  logic             mem_is_load_i,
  input  logic             mem_rdata_valid_i,
  input  logic [REG_W-1:0] mem_rd_index_i,
  input  logic [XLEN-1:0]  mem_alu_result_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic             wb_valid_i,
  input  logic [REG_W-1:0] wb_rd_index_i,
  input  logic [XLEN-1:0]  wb_value_i,
  output logic [XLEN-1:0]  value_o,
  output fwd_src_e         src_o,
  output logic             ex_load_hz_o,
  output logic             mem_wait_hz_o
);

  logic ex_hit, mem_hit, wb_hit;

  assign ex_hit  = ex_valid_i  && (ex_rd_index_i  == rs_index_i);
  assign mem_hit = mem_valid_i && (mem_rd_index_i == rs_index_i);
  assign wb_hit  = wb_valid_i  && (wb_rd_index_i  == rs_index_i);

  // On a hazard the value/src are don't-care: the stall keeps the EX register from loading them.
  always_comb begin
    value_o       = rs_value_i;
    src_o         = FWD_RF;
    ex_load_hz_o  = 1'b0;
    mem_wait_hz_o = 1'b0;
    if (rs_index_i == '0) begin
      value_o = '0;
    end else if (ex_hit) begin
      if (ex_is_load_i) begin
        ex_load_hz_o = 1'b1;
      end else begin
        value_o = ex_result_i;
        src_o   = FWD_EX;
      end
    end else if (mem_hit) begin
      if (!mem_is_load_i) begin
        value_o = mem_alu_result_i;
        src_o   = FWD_MEM_ALU;
      end else if (mem_rdata_valid_i) begin
        value_o = mem_rdata_i;
        src_o   = FWD_MEM_LOAD;
      end else begin
        mem_wait_hz_o = 1'b1;
      end
    end else if (wb_hit) begin
      value_o = wb_value_i;
      src_o   = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand forwarding and load-use / slow-memory stall unit
// between ID and EX. Selects each source from EX, MEM, WB or RF, stalls ID on
// hazards and registers the selected operands into the EX input register.
// Ports:
//   clk_i, reset_ni (sync, active-low)
//   id_*   : ID instruction, source indices and RF values (NUM_SRC packed)
//   ex_*, mem_*, wb_* : producer stages
//   ex_hold_i       : downstream freeze, EX register and FSM hold
//   id_stall_o      : combinational ID stall
//   exe_*_o, fwd_src_o : EX input register
//   hazard_state_o  : observational FSM state
//   stall_cnt_o     : saturating stall counter
// Macro HAZARD_STALL_CNT_EN: when defined the stall counter exists,
// otherwise stall_cnt_o is tied to 0.
//
// state    | meaning
// RUN      | no hazard seen on the last update
// LOAD_USE | a valid ID source depends on a load still in EX
// MEM_WAIT | a valid ID source depends on a load in MEM with data not yet returned
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_W-1:0]  id_rs_index_i,
  input  logic [NUM_SRC*XLEN-1:0]   id_rs_value_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_is_load_i,
  input  logic [REG_W-1:0]          ex_rd_index_i,
  input  logic [XLEN-1:0]           ex_result_i,
  input  logic                      mem_valid_i,
  input  logic                      mem_is_load_i,
  input  logic                      mem_rdata_valid_i,
  input  logic [REG_W-1:0]          mem_rd_index_i,
  input  logic [XLEN-1:0]           mem_alu_result_i,
  input  logic [XLEN-1:0]           mem_rdata_i,
  input  logic                      wb_valid_i,
  input  logic [REG_W-1:0]          wb_rd_index_i,
  input  logic [XLEN-1:0]           wb_value_i,
  input  logic                      ex_hold_i,
  output logic                      id_stall_o,
  output logic                      exe_valid_o,
  output logic [NUM_SRC*XLEN-1:0]   exe_rs_value_o,
  output logic [NUM_SRC*3-1:0]      fwd_src_o,
  output logic [1:0]                hazard_state_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  logic [NUM_SRC*XLEN-1:0] sel_val;
  logic [NUM_SRC*3-1:0]    sel_src;
  logic [NUM_SRC-1:0]      ex_load_hz;
  logic [NUM_SRC-1:0]      mem_wait_hz;
  logic                    load_use_hz;
  logic                    mem_wait_any;
  hz_state_e               state_q, state_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_e src;
    hazard_fwd_mux #(.XLEN(XLEN), .REG_W(REG_W)) u_mux (
      .rs_index_i        (id_rs_index_i[g*REG_W +: REG_W]),
      .rs_value_i        (id_rs_value_i[g*XLEN +: XLEN]),
      .ex_valid_i        (ex_valid_i),
      .ex_is_load_i      (ex_is_load_i),
      .ex_rd_index_i     (ex_rd_index_i),
      .ex_result_i       (ex_result_i),
      .mem_valid_i       (mem_valid_i),
      .mem_is_load_i     (mem_is_load_i),
      .mem_rdata_valid_i (mem_rdata_valid_i),
      .mem_rd_index_i    (mem_rd_index_i),
      .mem_alu_result_i  (mem_alu_result_i),
      .mem_rdata_i       (mem_rdata_i),
      .wb_valid_i        (wb_valid_i),
      .wb_rd_index_i     (wb_rd_index_i),
      .wb_value_i        (wb_value_i),
      .value_o           (sel_val[g*XLEN +: XLEN]),
      .src_o             (src),
      .ex_load_hz_o      (ex_load_hz[g]),
      .mem_wait_hz_o     (mem_wait_hz[g])
    );
    assign sel_src[g*3 +: 3] = src;
  end

  // Hazards only matter for a real instruction in ID.
  assign load_use_hz  = id_valid_i && (|ex_load_hz);
  assign mem_wait_any = id_valid_i && (|mem_wait_hz);
  assign id_stall_o   = id_valid_i && ((|ex_load_hz) || (|mem_wait_hz) || ex_hold_i);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      exe_valid_o    <= 1'b0;
      exe_rs_value_o <= '0;
      fwd_src_o      <= '0;
    end else if (ex_hold_i) begin
      exe_valid_o    <= exe_valid_o;
    end else if (id_stall_o) begin
      exe_valid_o    <= 1'b0;
    end else begin
      exe_valid_o    <= id_valid_i;
      exe_rs_value_o <= sel_val;
      fwd_src_o      <= sel_src;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_q <= RUN;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!ex_hold_i) begin
      if (load_use_hz)       state_d = LOAD_USE;
      else if (mem_wait_any) state_d = MEM_WAIT;
      else                   state_d = RUN;
    end
  end

  assign hazard_state_o = state_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      stall_cnt_q <= '0;
    end else if (id_stall_o && !ex_hold_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed test-plan scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_hazard_forward_unit;

  localparam int XLEN  = 32;
  localparam int NS    = 2;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;   // small so saturation is reached in the random run

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                  reset_ni;
  logic                  id_valid;
  logic [REG_W-1:0]      id_idx [NS];
  logic [XLEN-1:0]       id_val [NS];
  logic [NS*REG_W-1:0]   id_rs_index;
  logic [NS*XLEN-1:0]    id_rs_value;
  logic                  ex_valid, ex_ld;
  logic [REG_W-1:0]      ex_rd;
  logic [XLEN-1:0]       ex_res;
  logic                  mem_valid, mem_ld, mem_rdv;
  logic [REG_W-1:0]      mem_rd;
  logic [XLEN-1:0]       mem_alu, mem_rdata;
  logic                  wb_valid;
  logic [REG_W-1:0]      wb_rd;
  logic [XLEN-1:0]       wb_val;
  logic                  hold;

  logic                  id_stall_o, exe_valid_o;
  logic [NS*XLEN-1:0]    exe_rs_value_o;
  logic [NS*3-1:0]       fwd_src_o;
  logic [1:0]            hazard_state_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  always_comb begin
    id_rs_index = '0;
    id_rs_value = '0;
    for (int s = 0; s < NS; s++) begin
      id_rs_index[s*REG_W +: REG_W] = id_idx[s];
      id_rs_value[s*XLEN +: XLEN]   = id_val[s];
    end
  end

  hazard_forward_unit #(.XLEN(XLEN), .NUM_SRC(NS), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .id_valid_i(id_valid),
    .id_rs_index_i(id_rs_index), .id_rs_value_i(id_rs_value),
    .ex_valid_i(ex_valid), .ex_is_load_i(ex_ld), .ex_rd_index_i(ex_rd), .ex_result_i(ex_res),
    .mem_valid_i(mem_valid), .mem_is_load_i(mem_ld), .mem_rdata_valid_i(mem_rdv),
    .mem_rd_index_i(mem_rd), .mem_alu_result_i(mem_alu), .mem_rdata_i(mem_rdata),
    .wb_valid_i(wb_valid), .wb_rd_index_i(wb_rd), .wb_value_i(wb_val),
    .ex_hold_i(hold), .id_stall_o(id_stall_o), .exe_valid_o(exe_valid_o),
    .exe_rs_value_o(exe_rs_value_o), .fwd_src_o(fwd_src_o),
    .hazard_state_o(hazard_state_o), .stall_cnt_o(stall_cnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: origin codes 0 RF, 1 EX, 2 MEM ALU, 3 MEM load, 4 WB;
  // state 0 run, 1 load-use, 2 mem-wait.
  bit              m_valid;
  logic [XLEN-1:0] m_val [NS];
  int              m_src [NS];
  int              m_state;
  int              m_cnt;
  logic [XLEN-1:0] c_val [NS];
  int              c_src [NS];
  bit              c_ld, c_mw, c_stall;

  task automatic model_comb();
    c_ld = 0; c_mw = 0;
    for (int s = 0; s < NS; s++) begin
      int r;
      r = id_idx[s];
      c_val[s] = id_val[s];
      c_src[s] = 0;
      if (r == 0) c_val[s] = 0;
      else if (ex_valid && ex_rd == r) begin
        if (ex_ld) c_ld = 1;
        else begin c_val[s] = ex_res; c_src[s] = 1; end
      end else if (mem_valid && mem_rd == r) begin
        if (!mem_ld) begin c_val[s] = mem_alu; c_src[s] = 2; end
        else if (mem_rdv) begin c_val[s] = mem_rdata; c_src[s] = 3; end
        else c_mw = 1;
      end else if (wb_valid && wb_rd == r) begin
        c_val[s] = wb_val; c_src[s] = 4;
      end
    end
    c_stall = id_valid && (c_ld || c_mw || hold);
  endtask

  task automatic model_seq();
    if (!reset_ni) begin
      m_valid = 0; m_state = 0; m_cnt = 0;
      for (int s = 0; s < NS; s++) begin m_val[s] = 0; m_src[s] = 0; end
    end else if (!hold) begin
      m_state = (id_valid && c_ld) ? 1 : (id_valid && c_mw) ? 2 : 0;
      if (c_stall) begin
        m_valid = 0;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else begin
        m_valid = id_valid;
        for (int s = 0; s < NS; s++) begin m_val[s] = c_val[s]; m_src[s] = c_src[s]; end
      end
    end
  endtask

  task automatic check_regs();
    chk("exe_valid", 32'(exe_valid_o), 32'(m_valid));
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("exe_val%0d", s), exe_rs_value_o[s*XLEN +: XLEN], m_val[s]);
      chk($sformatf("fwd_src%0d", s), 32'(fwd_src_o[s*3 +: 3]), 32'(m_src[s]));
    end
    chk("state", 32'(hazard_state_o), 32'(m_state));
`ifdef HAZARD_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
`else
    chk("stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
  endtask

  // Inputs are set between edges; the stall is checked before the edge,
  // the registers one delta-step after it.
  task automatic step();
    #1;
    model_comb();
    chk("id_stall", 32'(id_stall_o), 32'(c_stall));
    @(posedge clk_i);
    model_seq();
    #1;
    check_regs();
  endtask

  task automatic idle_inputs();
    id_valid = 0; ex_valid = 0; ex_ld = 0; ex_rd = 0; ex_res = 0;
    mem_valid = 0; mem_ld = 0; mem_rdv = 0; mem_rd = 0; mem_alu = 0; mem_rdata = 0;
    wb_valid = 0; wb_rd = 0; wb_val = 0; hold = 0;
    for (int s = 0; s < NS; s++) begin id_idx[s] = 0; id_val[s] = 32'hDEAD_0000 + s; end
  endtask

  initial begin
    idle_inputs();
    reset_ni = 0;
    m_valid = 1; m_state = 3; m_cnt = 99;   // forces the reset step to really check
    @(posedge clk_i); #1;
    step();
    chk("rst_valid", 32'(exe_valid_o), 32'd0);
    reset_ni = 1;

    // EX bypass
    id_valid = 1; id_idx[0] = 3; id_idx[1] = 0;
    ex_valid = 1; ex_ld = 0; ex_rd = 3; ex_res = 32'h11;
    step();
    chk("exb_val", exe_rs_value_o[31:0], 32'h11);
    chk("exb_src", 32'(fwd_src_o[2:0]), 32'd1);
    chk("exb_valid", 32'(exe_valid_o), 32'd1);

    // Load-use then forward from MEM
    id_idx[0] = 0; id_idx[1] = 2; ex_ld = 1; ex_rd = 2;
    #1; chk("lu_stall", 32'(id_stall_o), 32'd1);
    step();
    chk("lu_valid", 32'(exe_valid_o), 32'd0);
    chk("lu_state", 32'(hazard_state_o), 32'd1);
    ex_valid = 0; mem_valid = 1; mem_ld = 1; mem_rdv = 1; mem_rd = 2; mem_rdata = 32'hAB;
    step();
    chk("lu_fwd_val", exe_rs_value_o[63:32], 32'hAB);
    chk("lu_fwd_src", 32'(fwd_src_o[5:3]), 32'd3);

    // Slow memory: 3 wait cycles from a clean counter, then data
    reset_ni = 0; step(); reset_ni = 1;
    mem_rdv = 0;
    repeat (3) step();
    chk("mw_state", 32'(hazard_state_o), 32'd2);
`ifdef HAZARD_STALL_CNT_EN
    chk("mw_cnt", 32'(stall_cnt_o), 32'd3);
`endif
    mem_rdv = 1; mem_rdata = 32'h5A5A;
    step();
    chk("mw_fwd", exe_rs_value_o[63:32], 32'h5A5A);

    // Priority and x0
    ex_valid = 1; ex_ld = 0; ex_rd = 5; ex_res = 32'h1;
    mem_valid = 1; mem_ld = 0; mem_rd = 5; mem_alu = 32'h2;
    wb_valid = 1; wb_rd = 5; wb_val = 32'h3;
    id_idx[0] = 5; id_idx[1] = 5;
    step();
    chk("prio_src", 32'(fwd_src_o[2:0]), 32'd1);
    ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_ld = 1; id_idx[0] = 0; id_idx[1] = 0;
    step();
    chk("x0_val", exe_rs_value_o[31:0], 32'd0);
    chk("x0_src", 32'(fwd_src_o[2:0]), 32'd0);

    // Hold during load-use, then release
    ex_rd = 4; id_idx[1] = 4; mem_valid = 0; wb_valid = 0;
    hold = 1;
    repeat (2) step();
    hold = 0;
    step();
    ex_valid = 0; mem_valid = 1; mem_ld = 1; mem_rdv = 1; mem_rd = 4; mem_rdata = 32'h44;
    step();

    // Reset while in MEM_WAIT
    mem_rdv = 0;
    repeat (2) step();
    reset_ni = 0;
    step();
    chk("rst_mw_state", 32'(hazard_state_o), 32'd0);
    reset_ni = 1;

    // Randomized traffic, small index range to make matches frequent
    for (int i = 0; i < 3000; i++) begin
      reset_ni  = ($urandom_range(0, 99) != 0);
      id_valid  = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NS; s++) begin
        id_idx[s] = REG_W'($urandom_range(0, 7));
        id_val[s] = $urandom;
      end
      ex_valid  = $urandom_range(0, 1); ex_ld = $urandom_range(0, 1);
      ex_rd     = REG_W'($urandom_range(0, 7)); ex_res = $urandom;
      mem_valid = $urandom_range(0, 1); mem_ld = $urandom_range(0, 1);
      mem_rdv   = $urandom_range(0, 1);
      mem_rd    = REG_W'($urandom_range(0, 7));
      mem_alu   = $urandom; mem_rdata = $urandom;
      wb_valid  = $urandom_range(0, 1);
      wb_rd     = REG_W'($urandom_range(0, 7)); wb_val = $urandom;
      hold      = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised operand-forwarding and load-use stall unit for the in-order RISC-V pipeline, replacing the fixed two-source EX/MEM bypass. Sits between ID and EX: selects each ID source operand from EX, MEM (ALU result or load data), WB or the register file. It detects load-use and slow-memory hazards, stalls ID, and registers the selected operands into the EX input register.

## Interface
Parameters:
- XLEN, 32, datapath width
- NUM_SRC, 2, source operands per instruction (1..3)
- REG_W, 5, register index width; index 0 is hard-wired zero
- CNT_W, 16, stall counter width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- reset_ni  in  1  synchronous, active-low reset
- id_valid_i  in  1  valid instruction in ID
- id_rs_index_i  in  NUM_SRC×REG_W  source indices in ID
- id_rs_value_i  in  NUM_SRC×XLEN  register-file read values
- ex_valid_i, ex_is_load_i  in  1 each  EX occupancy / EX holds a load
- ex_rd_index_i  in  REG_W  EX destination
- ex_result_i  in  XLEN  EX ALU result
- mem_valid_i, mem_is_load_i, mem_rdata_valid_i  in  1 each  MEM occupancy / load / load data ready
- mem_rd_index_i  in  REG_W  MEM destination
- mem_alu_result_i, mem_rdata_i  in  XLEN each  MEM ALU result / load data
- wb_valid_i  in  1  WB writes this cycle
- wb_rd_index_i  in  REG_W; wb_value_i  in  XLEN  WB destination and value
- ex_hold_i  in  1  downstream freeze; EX register must not change
- id_stall_o  out  1  ID must hold its instruction (combinational)
- exe_valid_o  out  1  EX input register valid
- exe_rs_value_o  out  NUM_SRC×XLEN  forwarded operands to EX
- fwd_src_o  out  NUM_SRC×3  registered source selection per operand (fwd_src_e)
- hazard_state_o  out  2  FSM state
- stall_cnt_o  out  CNT_W  stall cycle count (macro-dependent)

## Operation
- Per source s, the match is valid only if the index is non-zero and the producing stage is valid. Priority is EX > MEM > WB > RF.
- EX match, non-load: forward ex_result_i, src FWD_EX.
- EX match, load: load-use hazard; stall.
- MEM match: if mem_is_load_i=1 and mem_rdata_valid_i=1, forward mem_rdata_i (FWD_MEM_LOAD). If mem_is_load_i=1 and mem_rdata_valid_i=0, stall. If mem_is_load_i=0, forward mem_alu_result_i (FWD_MEM_ALU).
- WB match: wb_value_i (FWD_WB). No match: id_rs_value_i (FWD_RF).
- Index 0 always yields 0, FWD_RF, and never stalls.
- id_stall_o = id_valid_i & (any source hazard | ex_hold_i).
- EX register update, highest priority first:
  - !reset_ni: clear.
  - ex_hold_i: hold everything.
  - id_stall_o: exe_valid_o←0 (bubble); values and fwd_src hold.
  - Otherwise: exe_valid_o←id_valid_i; values and fwd_src←selected.
- FSM states: RUN=0, LOAD_USE=1, MEM_WAIT=2. State is updated only when ex_hold_i=0.
  - Next state is LOAD_USE if an EX-load hazard exists.
  - Otherwise MEM_WAIT if a MEM-wait hazard exists.
  - Otherwise RUN.
  - The state is observational only; the stall itself is decided combinationally.
- Multiple sources with different hazards: any hazard stalls; LOAD_USE wins for state.

## Timing
- Operand latency is 1 cycle: the selection made in cycle N appears on exe_rs_value_o in cycle N+1.
- Load-use costs at least 1 bubble. Cycle N: EX load matches, stall. Cycle N+1: the load is in MEM; forwarding happens if mem_rdata_valid_i=1, otherwise the stall continues each cycle until it rises.
- Reset values: exe_valid_o=0, exe_rs_value_o=0, fwd_src_o=FWD_RF, hazard_state_o=RUN, stall_cnt_o=0.
- Reset asserted mid-stall clears all state on the next edge; no bubble is carried over.
- ex_hold_i and a hazard in the same cycle: hold wins; no bubble is written.

## Configuration
- HAZARD_STALL_CNT_EN defined: stall_cnt_o increments on every edge with id_stall_o=1 and ex_hold_i=0. It saturates at 2^CNT_W−1 and clears only on reset.
- HAZARD_STALL_CNT_EN undefined: no counter register exists; stall_cnt_o is tied to 0.

## Structure
- hazard_pkg holds:
  - fwd_src_e: FWD_RF=0, FWD_EX=1, FWD_MEM_ALU=2, FWD_MEM_LOAD=3, FWD_WB=4.
  - hz_state_e: RUN, LOAD_USE, MEM_WAIT.
- Sub-module hazard_fwd_mux: combinational priority select for one source, producing value, src and hazard flags. It is instantiated NUM_SRC times via generate.
- The top level holds the FSM, the EX register and the counter.

## Test plan
- EX bypass: ADD x3 in EX with ex_result_i=0x11; ID rs0=x3 → next cycle exe_rs_value_o[0]=0x11, fwd_src_o[0]=FWD_EX, exe_valid_o=1.
- Load-use: LW x2 in EX; ID rs1=x2.
  - Required: id_stall_o=1, next cycle exe_valid_o=0, state LOAD_USE.
  - Then, with the load in MEM, mem_rdata_i=0xAB and rdata valid: exe_rs_value_o[1]=0xAB, FWD_MEM_LOAD.
- Slow memory: load in MEM with mem_rdata_valid_i=0 for 3 cycles → 3 stall cycles, state MEM_WAIT, stall_cnt_o=3 (with macro). Valid on the 4th cycle → forwards.
- Priority/x0: EX, MEM and WB all target x5 → FWD_EX chosen. rs=x0 with all stages targeting x0 → value 0, FWD_RF, no stall.
- ex_hold_i=1 during a load-use hazard → exe outputs unchanged, state unchanged; resumes correctly after release.
- reset_ni=0 in MEM_WAIT → next edge all outputs at reset values, and the counter clears.
